// File: rtl/dco_mtrx_decoder_p.sv
// dco_mtrx_decoder_p: drives a ROW_W x COL_W unit-cell DCO matrix from a
// binary target code. A registered target is approached by cur_code, then
// cur_code is decoded into row/column thermometer controls.
// Optional feature macro: DCO_DEC_SLEW_EN. When it is defined, cur_code moves
// at most MAX_STEP per cycle. When it is undefined, cur_code jumps to the
// target in one cycle.
// Load semantics: s_valid is a one-cycle strobe with no backpressure. Every
// edge with s_valid=1 captures s_mtrx as the new target.
module dco_mtrx_decoder_p #(
  parameter int ROW_W    = 16,
  parameter int COL_W    = 16,
  parameter int MAX_STEP = 4,
  localparam int BIN_W   = $clog2(ROW_W * COL_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BIN_W-1:0]             s_mtrx,
  input  logic                         s_valid,
  output logic [2*ROW_W+2*COL_W-1:0]   mtrx_thrm,
  output logic [BIN_W-1:0]             cur_code,
  output logic                         settled
);

  localparam int RB = $clog2(ROW_W);
  localparam int KB = BIN_W - RB;
  localparam int MW = 2 * ROW_W + 2 * COL_W;
  localparam logic [ROW_W-1:0] ROW_ONES = '1;
  localparam logic [COL_W-1:0] COL_ONES = '1;
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [MW-1:0]    RST_MTRX = {{(2 * ROW_W){1'b0}}, COL_ONE, ~COL_ONE};

  logic [BIN_W-1:0] target_q;
  logic [BIN_W-1:0] cur_next;
  logic [KB-1:0]    k;
  logic [RB-1:0]    r;
  logic [ROW_W-1:0] row_p;
  logic [ROW_W-1:0] row_n;
  logic [COL_W-1:0] col_on;
  logic [MW-1:0]    dec;

  // Matrix decode: columns 0..k are on. The partial column fills its unit
  // cells from the bottom on even columns and from the top on odd columns.
  always_comb begin
    k      = cur_code[BIN_W-1:RB];
    r      = cur_code[RB-1:0];
    col_on = ~(COL_ONES << (32'(k) + 32'd1));
    row_p  = ~(ROW_ONES << r);
    row_n  = '0;
    if (k[0]) begin
      row_p = ROW_ONES;
      row_n = ROW_ONES << (ROW_W - 32'(r));
    end
    dec = {row_p, row_n, col_on, ~col_on};
  end

`ifdef DCO_DEC_SLEW_EN
  localparam logic [BIN_W:0] STEP = (BIN_W + 1)'(MAX_STEP);
  logic [BIN_W:0] t_x;
  logic [BIN_W:0] c_x;
  logic [BIN_W:0] up_x;
  logic [BIN_W:0] dn_x;
  logic           unused_msb;

  // Slew-limited approach. The math uses one extra bit so the code never
  // wraps, and the final step lands exactly on the target.
  always_comb begin
    t_x      = {1'b0, target_q};
    c_x      = {1'b0, cur_code};
    up_x     = c_x + STEP;
    dn_x     = c_x - STEP;
    cur_next = target_q;
    if (t_x > c_x) begin
      if ((t_x - c_x) > STEP) cur_next = up_x[BIN_W-1:0];
    end else if ((c_x - t_x) > STEP) begin
      cur_next = dn_x[BIN_W-1:0];
    end
  end

  assign unused_msb = up_x[BIN_W] ^ dn_x[BIN_W];
`else
  logic unused_step;

  // Single-cycle jump to the target. The step limit has no effect here.
  always_comb begin
    cur_next = target_q;
  end

  assign unused_step = (MAX_STEP != 0);
`endif

  // State registers. Target, code, decoded matrix and settled advance in
  // lockstep, so the matrix shows the code from one cycle earlier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= '0;
      cur_code  <= '0;
      mtrx_thrm <= RST_MTRX;
      settled   <= 1'b1;
    end else begin
      if (s_valid) target_q <= s_mtrx;
      cur_code  <= cur_next;
      mtrx_thrm <= dec;
      settled   <= (cur_code == target_q);
    end
  end

endmodule

// File: tb/tb_dco_mtrx_decoder_p.sv
// Testbench for dco_mtrx_decoder_p.
// The driver issues a load or an idle cycle on each clock. It then updates a
// behavioural model and pushes the expected outputs into exp_q. A monitor
// pops one entry on every falling edge and compares it with the DUT.
module tb_dco_mtrx_decoder_p;
  localparam int ROW_W    = 16;
  localparam int COL_W    = 16;
  localparam int MAX_STEP = 4;
  localparam int BIN_W    = $clog2(ROW_W * COL_W);
  localparam int MW       = 2 * ROW_W + 2 * COL_W;
  localparam int EW       = BIN_W + MW + 1;

  logic             clk;
  logic             rst;
  logic [BIN_W-1:0] s_mtrx;
  logic             s_valid;
  logic [MW-1:0]    mtrx_thrm;
  logic [BIN_W-1:0] cur_code;
  logic             settled;

  dco_mtrx_decoder_p #(.ROW_W(ROW_W), .COL_W(COL_W), .MAX_STEP(MAX_STEP)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_mtrx    (s_mtrx),
    .s_valid   (s_valid),
    .mtrx_thrm (mtrx_thrm),
    .cur_code  (cur_code),
    .settled   (settled)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model. It holds the target, the code and the code the
  // matrix currently shows.
  int m_tgt;
  int m_cur;
  int m_shown;
  bit m_set;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] decode_ref(input int code);
    int k;
    int r;
    logic [ROW_W-1:0] rp;
    logic [ROW_W-1:0] rn;
    logic [COL_W-1:0] con;
    k = code / ROW_W;
    r = code % ROW_W;
    for (int j = 0; j < COL_W; j++) con[j] = (j <= k);
    for (int i = 0; i < ROW_W; i++) begin
      if (k % 2 == 0) begin
        rp[i] = (i < r);
        rn[i] = 1'b0;
      end else begin
        rp[i] = 1'b1;
        rn[i] = (i >= ROW_W - r);
      end
    end
    return {rp, rn, con, ~con};
  endfunction

  function automatic int ramp(input int cur, input int tgt);
`ifdef DCO_DEC_SLEW_EN
    if (tgt - cur > MAX_STEP) return cur + MAX_STEP;
    if (cur - tgt > MAX_STEP) return cur - MAX_STEP;
`endif
    return tgt;
  endfunction

  task automatic model_reset();
    m_tgt   = 0;
    m_cur   = 0;
    m_shown = 0;
    m_set   = 1'b1;
  endtask

  task automatic model_edge(input bit v, input int d);
    int n_cur;
    n_cur   = ramp(m_cur, m_tgt);
    m_shown = m_cur;
    m_set   = (m_cur == m_tgt);
    m_cur   = n_cur;
    if (v) m_tgt = d;
  endtask

  function automatic logic [EW-1:0] expected();
    return {BIN_W'(m_cur), decode_ref(m_shown), m_set};
  endfunction

  // Driver tasks
  task automatic step(input bit v, input int d);
    s_valid = v;
    s_mtrx  = BIN_W'(d);
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(v, d);
    exp_q.push_back(expected());
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 255));
  endtask

  task automatic apply_reset(input int cycles);
    logic [EW-1:0] e;
    @(negedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    e = expected();
    check("rst_cur_code", MW'(cur_code), MW'(e[EW-1 -: BIN_W]));
    check("rst_mtrx_thrm", mtrx_thrm, e[MW:1]);
    check("rst_settled", MW'(settled), MW'(e[0]));
    for (int i = 0; i < cycles; i++) step(1'b0, 0);
    rst = 1'b0;
  endtask

  // Monitor: one comparison set per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("cur_code", MW'(cur_code), MW'(mon_e[EW-1 -: BIN_W]));
      check("mtrx_thrm", mtrx_thrm, mon_e[MW:1]);
      check("settled", MW'(settled), MW'(mon_e[0]));
    end
  end

  // Stimulus
  initial begin
    rst     = 1'b0;
    s_valid = 1'b0;
    s_mtrx  = '0;
    model_reset();
    apply_reset(3);
    idle(2);
    // Decode table points
    step(1'b1, 17);  idle(10);
    step(1'b1, 33);  idle(10);
    step(1'b1, 255); idle(70);
    // Hold at the top code, then reload the same code
    step(1'b1, 255); idle(3);
    // Return to zero, then hold at the bottom
    step(1'b1, 0);   idle(70);
    step(1'b1, 0);   idle(3);
    // Ramp to 20
    step(1'b1, 20);  idle(8);
    step(1'b1, 0);   idle(8);
    // Redirect mid-ramp
    step(1'b1, 40);  idle(3);
    step(1'b1, 10);  idle(10);
    // Reset mid-ramp
    step(1'b1, 200); idle(5);
    apply_reset(2);
    idle(10);
    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 99))
        0:       apply_reset($urandom_range(1, 3));
        1, 2:    step(1'b1, m_tgt);
        3:       step(1'b1, 0);
        4:       step(1'b1, 255);
        default: step($urandom_range(0, 3) == 0, $urandom_range(0, 255));
      endcase
    end
    idle(3);
    @(negedge clk);
    #1;
    check("queue_drained", MW'(exp_q.size()), MW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
